// File: rtl/hamming_cost_pipe.sv
// Pipelined census Hamming-cost unit: one left word vs N_CH right words per beat.
// Optional macro MIN_SEARCH_EN adds a fourth stage reporting the per-beat minimum cost and channel.

module hamming_cost_lane #(
   parameter int W     = 32,
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   input  logic [W-1:0]     x,
   input  logic [W-1:0]     y,
   output logic [OUT_W-1:0] res
);
   localparam int G  = W / 8;
   localparam int SW = $clog2(W + 1);

   logic [W-1:0]      d;
   logic [G-1:0][3:0] p;
   logic [SW-1:0]     s;
   logic              sat;

   always_comb begin
      s = '0;
      for (int g = 0; g < G; g++) s = s + SW'(p[g]);
   end

   // 64-bit compare keeps the saturation limit exact for any legal OUT_W
   assign sat = ({32'd0, 32'(s)} > ((64'd1 << OUT_W) - 64'd1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d   <= '0;
         p   <= '0;
         res <= '0;
      end else if (adv) begin
         d <= x ^ y;
         for (int g = 0; g < G; g++) p[g] <= 4'($countones(d[8*g +: 8]));
         res <= sat ? '1 : OUT_W'(s);
      end
   end
endmodule

module hamming_cost_pipe #(
   parameter int  W     = 32,
   parameter int  N_CH  = 4,
   parameter int  OUT_W = 8,
   localparam int IW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W-1:0]          x,
   input  logic [N_CH*W-1:0]     y,
   output logic                  out_valid,
   input  logic                  out_ready,
`ifdef MIN_SEARCH_EN
   output logic [OUT_W-1:0]      min_cost,
   output logic [IW-1:0]         min_idx,
`endif
   output logic [N_CH*OUT_W-1:0] res
);
`ifdef MIN_SEARCH_EN
   localparam int STAGES = 4;
`else
   localparam int STAGES = 3;
`endif

   logic                        adv;
   logic [STAGES:1]             vld_pipe;
   logic [N_CH-1:0][OUT_W-1:0]  lane_res;

   // The whole pipe moves together; only a held output blocks it
   assign adv       = !(out_valid && !out_ready);
   assign in_ready  = adv;
   assign out_valid = vld_pipe[STAGES];

   always_ff @(posedge clk) begin
      if (!rst_n)   vld_pipe <= '0;
      else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_lane
      hamming_cost_lane #(.W(W), .OUT_W(OUT_W)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .adv   (adv),
         .x     (x),
         .y     (y[c*W +: W]),
         .res   (lane_res[c])
      );
   end

`ifdef MIN_SEARCH_EN
   logic [N_CH-1:0][OUT_W-1:0] res_q;
   logic [OUT_W-1:0]           mc;
   logic [IW-1:0]              mi;

   // Strict less-than so ties resolve to the lowest channel
   always_comb begin
      mc = lane_res[0];
      mi = '0;
      for (int c = 1; c < N_CH; c++) begin
         if (lane_res[c] < mc) begin
            mc = lane_res[c];
            mi = IW'(c);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_q    <= '0;
         min_cost <= '0;
         min_idx  <= '0;
      end else if (adv) begin
         res_q    <= lane_res;
         min_cost <= mc;
         min_idx  <= mi;
      end
   end

   assign res = res_q;
`else
   assign res = lane_res;
`endif
endmodule

// File: tb/tb_hamming_cost_pipe.sv
// Directed bench for hamming_cost_pipe; main instance W=32/N_CH=4/OUT_W=8, second instance W=64/N_CH=2/OUT_W=5 for saturation.
module tb_hamming_cost_pipe;
`ifdef MIN_SEARCH_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [31:0]  x;
   logic [127:0] y;
   logic [31:0]  res;
   logic         v2, r2, ov2;
   logic [63:0]  x2;
   logic [127:0] y2;
   logic [9:0]   res2;
`ifdef MIN_SEARCH_EN
   logic [7:0]   min_cost;
   logic [1:0]   min_idx;
   logic [4:0]   min_cost2;
   logic [0:0]   min_idx2;
`endif

   always #5 clk = ~clk;

   hamming_cost_pipe #(.W(32), .N_CH(4), .OUT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
`ifdef MIN_SEARCH_EN
      .min_cost(min_cost), .min_idx(min_idx),
`endif
      .res(res));

   hamming_cost_pipe #(.W(64), .N_CH(2), .OUT_W(5)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2),
      .x(x2), .y(y2), .out_valid(ov2), .out_ready(1'b1),
`ifdef MIN_SEARCH_EN
      .min_cost(min_cost2), .min_idx(min_idx2),
`endif
      .res(res2));

   int          vectors = 0, miscompares = 0;
   int          sent, got;
   logic        stalled, pending;
   logic [31:0] held_res, er, cst;
   logic [9:0]  em;
   logic [31:0] exp_res[$];
   logic [9:0]  exp_min[$];
   logic [15:0] ivh;
   logic [7:0]  mc;
   logic [1:0]  mi;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one beat, then wait until its result should be on the outputs
   task automatic run_single(input logic [31:0] xv, input logic [127:0] yv);
      @(negedge clk);
      in_valid = 1'b1; x = xv; y = yv;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (LAT - 1) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; x = '0; y = '0;
      v2 = 1'b1; x2 = '0; y2 = '0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_res", res, 0);
      rst_n = 1'b1; in_valid = 1'b0; v2 = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_res2", res2, 0);

      // Basic costs and latency; saturation on the wide instance in parallel
      @(negedge clk);
      in_valid = 1'b1; x = 32'h0;
      y = {32'hFFFFFFFF, 32'h0000000F, 32'h00000000, 32'h80000001};
      v2 = 1'b1; x2 = 64'h0;
      y2 = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_000F_FFFF};
      for (int i = 1; i <= LAT; i++) begin
         @(negedge clk);
         in_valid = 1'b0; v2 = 1'b0;
         if (i < LAT) check("lat_early_valid", out_valid, 0);
      end
      check("lat_valid", out_valid, 1);
      check("basic_res", res, {8'd32, 8'd4, 8'd0, 8'd2});
      check("sat_valid", ov2, 1);
      check("sat_res", res2, {5'd31, 5'd20});
`ifdef MIN_SEARCH_EN
      check("basic_min_cost", min_cost, 0);
      check("basic_min_idx", min_idx, 1);
      check("sat_min_cost", min_cost2, 20);
      check("sat_min_idx", min_idx2, 0);
`endif
      @(negedge clk);
      check("single_beat_once", out_valid, 0);

      // Every channel at cost 7
      run_single(32'h0, {4{32'h0000007F}});
      check("tie_valid", out_valid, 1);
      check("tie_res", res, {4{8'd7}});
`ifdef MIN_SEARCH_EN
      check("tie_min_cost", min_cost, 7);
      check("tie_min_idx", min_idx, 0);
`endif
      run_single(32'hA5A5A5A5, {32'h5A5A5A5A, 32'hA5A5A5A5, 32'hA5A5A5A4, 32'hA5A5A5A5});
      check("eq_inv_res", res, {8'd32, 8'd0, 8'd1, 8'd0});
`ifdef MIN_SEARCH_EN
      check("eq_inv_min_idx", min_idx, 0);
`endif

      // Backpressure with out_ready = 1,0,0,1 and a scoreboard
      sent = 0; got = 0; stalled = 1'b0; pending = 1'b0; held_res = '0;
      for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
         @(negedge clk);
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         if (sent < 10) begin
            if (!pending) begin
               x = $urandom;
               y = {$urandom, $urandom, $urandom, $urandom};
               pending = 1'b1;
            end
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (stalled) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_res", res, held_res);
         end
         check("bp_in_ready", in_ready, !(out_valid && !out_ready));
         if (in_valid && in_ready) begin
            er = '0; mc = 8'hFF; mi = '0;
            for (int c = 0; c < 4; c++) begin
               cst = 32'($countones(x ^ y[c*32 +: 32]));
               er[c*8 +: 8] = cst[7:0];
               if (cst[7:0] < mc) begin mc = cst[7:0]; mi = 2'(c); end
            end
            exp_res.push_back(er);
            exp_min.push_back({mc, mi});
            sent++;
            pending = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (exp_res.size() == 0) begin
               check("bp_extra_output", 1, 0);
            end else begin
               er = exp_res.pop_front();
               em = exp_min.pop_front();
               check("bp_res", res, er);
`ifdef MIN_SEARCH_EN
               check("bp_min", {min_cost, min_idx}, em);
`endif
            end
            got++;
         end
         stalled  = out_valid && !out_ready;
         held_res = res;
      end
      check("bp_count", got, 10);
      in_valid = 1'b0; out_ready = 1'b1;

      // Bubbles: alternating in_valid must reappear LAT cycles later
      repeat (LAT + 1) @(negedge clk);
      ivh = '0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         in_valid = (i < 8) && (i % 2 == 0);
         ivh[i]   = in_valid;
         #1;
         check("bubble_valid", out_valid, (i >= LAT) ? ivh[i-LAT] : 1'b0);
      end

      // Reset while stalled flushes the pipe
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1;
      repeat (LAT + 2) @(negedge clk);
      #1;
      check("stall_in_ready", in_ready, 0);
      rst_n = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("flush_in_ready", in_ready, 1);
      check("flush_valid", out_valid, 0);
      check("flush_res", res, 0);
      repeat (LAT) @(negedge clk);
      check("flush_no_ghost", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
